wave_sequencer: RTL and testbench
=================================

Name: wave_sequencer

Overview:
- Programmable sequencer for the square-wave output.
- Holds a 4-entry pattern table. Each entry gives an ON multiplier, an OFF multiplier and a repeat count.
- Plays the entries in order, each as one or more ON/OFF periods built from a base interval of CYCLES clocks.
- Sits between the DIP-switch/host write logic and the LED/scope pin. It replaces fixed m/n decoding with a sequenced multi-step pattern.

Parameters:
- CYCLES, 1200000, clocks per unit interval (the prescaler terminal count is CYCLES-1).
- PW, 21, prescaler width; must satisfy 2^PW >= CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin the pattern at entry 0
- stop  in  1  single-cycle abort request
- loop  in  1  1 = wrap to entry 0 after the pattern ends; sampled when an entry completes
- wr_en  in  1  table write strobe
- wr_addr  in  2  table entry index
- wr_on  in  4  ON multiplier, 0..15 units
- wr_off  in  4  OFF multiplier, 0..15 units
- wr_rep  in  4  extra repetitions of the entry (rep+1 periods in total)
- out  out  1  square-wave output (LED/scope), registered
- busy  out  1  high whenever state != IDLE
- step_idx  out  2  index of the entry currently playing; 0 in IDLE
- done  out  1  one-cycle pulse when the pattern ends or is aborted

Behaviour:
- Reset, asynchronous:
  - state=IDLE; all table entries =0.
  - out=0, busy=0, step_idx=0, done=0; prescaler, unit and repeat counters =0.
- Table writes:
  - A write takes effect on the next edge and is accepted in any state.
  - The active entry's on/off/rep are latched into working registers when the entry is entered, so a write to the playing entry takes effect on its next visit.
- An entry with on=0 and off=0 is the END marker. Its rep field is ignored.
- States: IDLE, ON, OFF.
- Phase entry rule, for entry e with repeat counter r:
  - if on!=0, go to ON;
  - else if off!=0, go to OFF;
  - else END.
- Prescaler:
  - Counts 0..CYCLES-1 and restarts at 0 on every phase entry.
  - tick = prescaler==CYCLES-1.
  - A unit counter counts ticks. A phase of k units lasts exactly k*CYCLES clocks.
- IDLE + start (and not stop):
  - Entry 0 is loaded and the phase entry rule applies on the same edge.
  - If entry 0 is END: done pulses on the next cycle and state stays IDLE.
- ON:
  - out=1.
  - On the tick that completes `on` units: go to OFF if off!=0, otherwise take the period-complete step.
- OFF:
  - out=0.
  - On the tick that completes `off` units: take the period-complete step.
- Period-complete step:
  - If r<rep: r++, same entry, apply the phase entry rule.
  - Otherwise: r=0 and advance e.
- Advancing e:
  - e+1; entry 3 wraps to 0.
  - The new entry is loaded and the phase entry rule applies on the same edge, so there is no dead cycle between periods or entries.
- END reached (END marker, or wrap after entry 3):
  - If loop=1 and the END is not at entry 0: continue at entry 0.
  - Otherwise: IDLE, done=1 for one cycle, out=0.
  - An END at entry 0 always terminates, which prevents livelock.
- stop in a non-IDLE state:
  - Next edge: IDLE, out=0, done=1, step_idx=0.
  - stop takes priority over start and over phase completion on the same edge.
- start while busy is ignored. stop while IDLE is ignored and produces no done pulse.
- out, busy, step_idx and done are registered and glitch-free.
- Duty per entry = on/(on+off). Period = (on+off)*CYCLES clocks.

Test Plan:
- Reset mid-ON with CYCLES=4: assert reset_n=0 asynchronously -> out=0, busy=0 immediately; all table entries read back as 0 (start afterwards gives an immediate done, busy stays 0).
- CYCLES=4, table {0:(on2,off1,rep1), 1:(1,3,0), 2:(0,0,x)}, loop=0, start -> out high 8, low 4, high 8, low 4, high 4, low 12 clocks; step_idx 0 then 1; done one cycle after the last OFF clock; busy falls with it.
- Same table, loop=1 -> after entry 1 the sequence restarts at entry 0 with no gap and continues until stop; stop -> out=0 and done=1 on the next edge.
- Zero phases, entry 0=(0,2,0), entry 1=(3,0,0), entry 2=END -> low 8, high 12, then done; out never shows a 1-cycle glitch.
- Write entry 0 to (5,5,0) while entry 0 plays as (1,1,2) -> the current repeats keep 4 clocks high / 4 low; the new values apply only on the next visit.
- start and stop asserted on the same edge in IDLE -> stays IDLE, no done. start while busy -> no effect on timing.

Source files
------------

// File: rtl/wave_sequencer.sv
// -----------------------------------------------------------------------------
// wave_sequencer
// Plays a 4-entry pattern table on the square-wave output. Each entry holds
// an ON multiplier, an OFF multiplier and a repeat count; one period of an
// entry is `on` units high followed by `off` units low, where a unit is
// CYCLES clocks. An entry with on=0 and off=0 marks the end of the pattern.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset (clears table and all state)
//   start     one-cycle request to play from entry 0 (ignored while busy)
//   stop      one-cycle abort (ignored while idle)
//   loop      restart at entry 0 when the pattern ends, sampled at entry end
//   wr_en     table write strobe, accepted in any state
//   wr_addr   table entry index
//   wr_on     ON multiplier (units)
//   wr_off    OFF multiplier (units)
//   wr_rep    extra repetitions of the entry (rep+1 periods in total)
//   out       registered square-wave output
//   busy      registered, high while a pattern is playing
//   step_idx  registered index of the playing entry, 0 when idle
//   done      registered one-cycle pulse when the pattern ends or is aborted
// -----------------------------------------------------------------------------
module wave_sequencer #(
   parameter int CYCLES = 1200000,
   parameter int PW     = 21
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_on,
   input  logic [3:0] wr_off,
   input  logic [3:0] wr_rep,
   output logic       out,
   output logic       busy,
   output logic [1:0] step_idx,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [3:0]    on_tab_r  [4];
   logic [3:0]    off_tab_r [4];
   logic [3:0]    rep_tab_r [4];

   state_t        state_r, state_s;
   logic [1:0]    e_r, e_s;
   logic [3:0]    r_r, r_s;
   logic [3:0]    cur_on_r, cur_on_s;
   logic [3:0]    cur_off_r, cur_off_s;
   logic [3:0]    cur_rep_r, cur_rep_s;
   logic [PW-1:0] pre_r, pre_s;
   logic [3:0]    unit_r, unit_s;
   logic          done_s;

   logic          out_r, busy_r, done_r;
   logic [1:0]    step_r;

   logic          tick_s, phase_done_s, inc_end_s, zero_end_s;
   logic [1:0]    e_inc_s;
   logic [3:0]    phase_len_s;
   logic          load_s, finish_s, rephase_s;
   logic [1:0]    load_idx_s;

   assign tick_s       = (pre_r == PRE_LAST);
   assign phase_len_s  = (state_r == ST_ON) ? cur_on_r : cur_off_r;
   assign phase_done_s = tick_s && (unit_r == (phase_len_s - 4'd1));
   assign e_inc_s      = e_r + 2'd1;
   assign inc_end_s    = (on_tab_r[e_inc_s] == 4'd0) && (off_tab_r[e_inc_s] == 4'd0);
   assign zero_end_s   = (on_tab_r[0] == 4'd0) && (off_tab_r[0] == 4'd0);

   // Pattern table write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            on_tab_r[i]  <= 4'd0;
            off_tab_r[i] <= 4'd0;
            rep_tab_r[i] <= 4'd0;
         end
      end else if (wr_en) begin
         on_tab_r[wr_addr]  <= wr_on;
         off_tab_r[wr_addr] <= wr_off;
         rep_tab_r[wr_addr] <= wr_rep;
      end
   end

   // Next-state logic: decide the transition, then apply entry loading,
   // same-entry repeat or termination on top of the default counting.
   always_comb begin
      state_s    = state_r;
      e_s        = e_r;
      r_s        = r_r;
      cur_on_s   = cur_on_r;
      cur_off_s  = cur_off_r;
      cur_rep_s  = cur_rep_r;
      pre_s      = tick_s ? {PW{1'b0}} : (pre_r + PRE_ONE);
      unit_s     = tick_s ? (unit_r + 4'd1) : unit_r;
      done_s     = 1'b0;
      load_s     = 1'b0;
      load_idx_s = 2'd0;
      finish_s   = 1'b0;
      rephase_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            pre_s  = {PW{1'b0}};
            unit_s = 4'd0;
            if (start && !stop) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         ST_ON, ST_OFF: begin
            if (stop) begin
               finish_s = 1'b1;
            end else if (phase_done_s) begin
               if ((state_r == ST_ON) && (cur_off_r != 4'd0)) begin
                  state_s = ST_OFF;
                  pre_s   = {PW{1'b0}};
                  unit_s  = 4'd0;
               end else if (r_r < cur_rep_r) begin
                  r_s       = r_r + 4'd1;
                  rephase_s = 1'b1;
               end else if ((e_r != 2'd3) && !inc_end_s) begin
                  load_s     = 1'b1;
                  load_idx_s = e_inc_s;
               end else if (loop && !zero_end_s) begin
                  // End of pattern with looping; an END at entry 0 never loops.
                  load_s     = 1'b1;
                  load_idx_s = 2'd0;
               end else begin
                  finish_s = 1'b1;
               end
            end else begin
               finish_s = 1'b0;
            end
         end
         default: begin
            finish_s = 1'b1;
         end
      endcase

      if (rephase_s) begin
         pre_s   = {PW{1'b0}};
         unit_s  = 4'd0;
         state_s = (cur_on_r != 4'd0) ? ST_ON : ST_OFF;
      end else begin
         rephase_s = 1'b0;
      end

      if (load_s) begin
         e_s       = load_idx_s;
         r_s       = 4'd0;
         cur_on_s  = on_tab_r[load_idx_s];
         cur_off_s = off_tab_r[load_idx_s];
         cur_rep_s = rep_tab_r[load_idx_s];
         pre_s     = {PW{1'b0}};
         unit_s    = 4'd0;
         if (on_tab_r[load_idx_s] != 4'd0) begin
            state_s = ST_ON;
         end else if (off_tab_r[load_idx_s] != 4'd0) begin
            state_s = ST_OFF;
         end else begin
            // Only reachable from IDLE: entry 0 is an END marker.
            state_s = ST_IDLE;
            done_s  = 1'b1;
            e_s     = 2'd0;
         end
      end else begin
         load_s = 1'b0;
      end

      if (finish_s) begin
         state_s = ST_IDLE;
         done_s  = 1'b1;
         e_s     = 2'd0;
         r_s     = 4'd0;
         pre_s   = {PW{1'b0}};
         unit_s  = 4'd0;
      end else begin
         finish_s = 1'b0;
      end
   end

   // State, working registers and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         e_r       <= 2'd0;
         r_r       <= 4'd0;
         cur_on_r  <= 4'd0;
         cur_off_r <= 4'd0;
         cur_rep_r <= 4'd0;
         pre_r     <= {PW{1'b0}};
         unit_r    <= 4'd0;
         out_r     <= 1'b0;
         busy_r    <= 1'b0;
         step_r    <= 2'd0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         e_r       <= e_s;
         r_r       <= r_s;
         cur_on_r  <= cur_on_s;
         cur_off_r <= cur_off_s;
         cur_rep_r <= cur_rep_s;
         pre_r     <= pre_s;
         unit_r    <= unit_s;
         out_r     <= (state_s == ST_ON);
         busy_r    <= (state_s != ST_IDLE);
         step_r    <= e_s;
         done_r    <= done_s;
      end
   end

   assign out      = out_r;
   assign busy     = busy_r;
   assign step_idx = step_r;
   assign done     = done_r;

endmodule

// File: tb/tb_wave_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wave_sequencer
// Directed bench for wave_sequencer with CYCLES=4. Inputs change and outputs
// are sampled on the falling clock edge; expected waveforms are built from
// hand-computed segment lists.
// -----------------------------------------------------------------------------
module tb_wave_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       stop;
   logic       loop;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [3:0] wr_on;
   logic [3:0] wr_off;
   logic [3:0] wr_rep;
   logic       out;
   logic       busy;
   logic [1:0] step_idx;
   logic       done;

   int n_checks;
   int n_pass;
   bit exp_q[$];

   wave_sequencer #(.CYCLES(4), .PW(3)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .stop     (stop),
      .loop     (loop),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_on    (wr_on),
      .wr_off   (wr_off),
      .wr_rep   (wr_rep),
      .out      (out),
      .busy     (busy),
      .step_idx (step_idx),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add_seg(input bit v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v);
   endfunction

   task automatic write_entry(input logic [1:0] a, input logic [3:0] on_v,
                              input logic [3:0] off_v, input logic [3:0] rep_v);
      wr_en = 1'b1; wr_addr = a; wr_on = on_v; wr_off = off_v; wr_rep = rep_v;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_basic_table();
      write_entry(2'd0, 4'd2, 4'd1, 4'd1);
      write_entry(2'd1, 4'd1, 4'd3, 4'd0);
      write_entry(2'd2, 4'd0, 4'd0, 4'd5);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (out !== 1'b0 || busy !== 1'b0 || step_idx !== 2'd0 || done !== 1'b0)
         $display("FAIL reset_state out=%b busy=%b step=%0d done=%b expected all 0", out, busy, step_idx, done);
      else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_basic_table();
      loop = 1'b0;
      exp_q.delete();
      add_seg(1'b1, 8); add_seg(1'b0, 4); add_seg(1'b1, 8); add_seg(1'b0, 4);
      add_seg(1'b1, 4); add_seg(1'b0, 12);
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL basic_wave cyc=%0d out=%b busy=%b done=%b expected out=%b busy=1 done=0", i, out, busy, done, exp_q[i]);
         else n_pass++;
         n_checks++;
         if (step_idx !== ((i < 24) ? 2'd0 : 2'd1))
            $display("FAIL basic_step cyc=%0d step=%0d expected %0d", i, step_idx, (i < 24) ? 0 : 1);
         else n_pass++;
         @(negedge clk);
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0 || step_idx !== 2'd0)
         $display("FAIL basic_end done=%b busy=%b out=%b step=%0d expected done=1 busy=0 out=0 step=0", done, busy, out, step_idx);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_done_width done=%b busy=%b expected 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_loop();
      loop = 1'b1;
      exp_q.delete();
      add_seg(1'b1, 8); add_seg(1'b0, 4); add_seg(1'b1, 8); add_seg(1'b0, 4);
      add_seg(1'b1, 4); add_seg(1'b0, 12); add_seg(1'b1, 8); add_seg(1'b0, 2);
      pulse_start();
      for (int i = 0; i < 50; i++) begin
         n_checks++;
         if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL loop_wave cyc=%0d out=%b busy=%b done=%b expected out=%b busy=1 done=0", i, out, busy, done, exp_q[i]);
         else n_pass++;
         if (i >= 40 && i < 48) begin
            n_checks++;
            if (step_idx !== 2'd0)
               $display("FAIL loop_restart_step cyc=%0d step=%0d expected 0", i, step_idx);
            else n_pass++;
         end
         if (i == 49) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0 || step_idx !== 2'd0)
         $display("FAIL loop_stop done=%b busy=%b out=%b step=%0d expected done=1 busy=0 out=0 step=0", done, busy, out, step_idx);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0)
         $display("FAIL loop_stop_done_width done=%b expected 0", done);
      else n_pass++;
      loop = 1'b0;
   endtask

   task automatic test_reset_mid_on();
      load_basic_table();
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (out !== 1'b1)
         $display("FAIL pre_reset_on out=%b expected 1", out);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 2'd0)
         $display("FAIL async_reset out=%b busy=%b done=%b step=%0d expected all 0", out, busy, done, step_idx);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      pulse_start();
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0)
         $display("FAIL cleared_table_start done=%b busy=%b out=%b expected done=1 busy=0 out=0", done, busy, out);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL cleared_table_after done=%b busy=%b expected 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_zero_phases();
      write_entry(2'd0, 4'd0, 4'd2, 4'd0);
      write_entry(2'd1, 4'd3, 4'd0, 4'd0);
      write_entry(2'd2, 4'd0, 4'd0, 4'd0);
      loop = 1'b0;
      exp_q.delete();
      add_seg(1'b0, 8); add_seg(1'b1, 12);
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL zero_phase_wave cyc=%0d out=%b busy=%b done=%b expected out=%b busy=1 done=0", i, out, busy, done, exp_q[i]);
         else n_pass++;
         @(negedge clk);
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0)
         $display("FAIL zero_phase_end done=%b busy=%b out=%b expected done=1 busy=0 out=0", done, busy, out);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_live_write();
      write_entry(2'd0, 4'd1, 4'd1, 4'd2);
      write_entry(2'd1, 4'd0, 4'd0, 4'd0);
      loop = 1'b1;
      exp_q.delete();
      add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 4);
      add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 20); add_seg(1'b0, 20);
      pulse_start();
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL live_write_wave cyc=%0d out=%b busy=%b done=%b expected out=%b busy=1 done=0", i, out, busy, done, exp_q[i]);
         else n_pass++;
         if (i == 2) begin
            wr_en = 1'b1; wr_addr = 2'd0; wr_on = 4'd5; wr_off = 4'd5; wr_rep = 4'd0;
         end else begin
            wr_en = 1'b0;
         end
         if (i == 63) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0)
         $display("FAIL live_write_stop done=%b busy=%b out=%b expected done=1 busy=0 out=0", done, busy, out);
      else n_pass++;
      loop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_start_stop();
      write_entry(2'd0, 4'd1, 4'd1, 4'd0);
      write_entry(2'd1, 4'd0, 4'd0, 4'd0);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL start_stop_idle busy=%b done=%b expected 0 0", busy, done);
      else n_pass++;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL stop_idle busy=%b done=%b expected 0 0", busy, done);
      else n_pass++;
      exp_q.delete();
      add_seg(1'b1, 4); add_seg(1'b0, 4);
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL start_busy_wave cyc=%0d out=%b busy=%b done=%b expected out=%b busy=1 done=0", i, out, busy, done, exp_q[i]);
         else n_pass++;
         start = (i == 2) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0)
         $display("FAIL start_busy_end done=%b busy=%b out=%b expected done=1 busy=0 out=0", done, busy, out);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      loop     = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = 2'd0;
      wr_on    = 4'd0;
      wr_off   = 4'd0;
      wr_rep   = 4'd0;
      test_reset();
      test_basic();
      test_loop();
      test_reset_mid_on();
      test_zero_phases();
      test_live_write();
      test_start_stop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
